// File: rtl/tpbuf_pkg.sv
// Shared types and helpers for the transpose-DMA line buffer responder.
package tpbuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_CLEAR = 3'b010,
    ST_DONE  = 3'b100
  } state_t;

  localparam int CNT_W = 32;

  // Compared at 64 bits so no address bits are lost for any AW up to 64.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/tpbuf_rd_pipe.sv
// Fixed-latency read return pipe: STAGES registers carrying {vld, data}.
module tpbuf_rd_pipe #(
  parameter int DATA_W = 512,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_data,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_data
);

  logic              vld_p  [STAGES];
  logic [DATA_W-1:0] data_p [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= load_vld;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // p0 is loaded from the memory/forwarding mux; later stages only delay
  always_ff @(posedge clk) begin
    data_p[0] <= load_data;
    for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
  end

  assign rsp_vld  = vld_p[STAGES-1];
  assign rsp_data = data_p[STAGES-1];

endmodule

// File: rtl/tp_buf_responder.sv
// Line buffer answering the DMA read/write request streams, with zero-fill and traffic counters.
module tp_buf_responder
  import tpbuf_pkg::*;
#(
  parameter int AW     = 16,
  parameter int BUFFD  = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_req,
  output logic               busy,
  output logic               clr_done,
  input  logic [AW-1:0]      raddr,
  input  logic               raddr_vld,
  output logic [BUFFD*8-1:0] rdata,
  output logic               rdata_vld,
  input  logic [AW-1:0]      waddr,
  input  logic [BUFFD*8-1:0] wdata,
  input  logic               wdata_vld,
  output logic               acc_err,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt
);

  localparam int DW = BUFFD * 8;
  localparam int IW = $clog2(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t        state;
  logic [IW-1:0] clr_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          rd_in, wr_in, serving, wr_en;
  logic [IW-1:0] ridx, widx;
  logic [DW-1:0] rd_mux;
  logic          pipe_vld;
  logic [DW-1:0] pipe_data;

  assign rd_in   = in_range(64'(raddr), 64'(DEPTH));
  assign wr_in   = in_range(64'(waddr), 64'(DEPTH));
  assign ridx    = raddr[IW-1:0];
  assign widx    = waddr[IW-1:0];
  assign serving = (state != ST_CLEAR);
  assign wr_en   = serving && wdata_vld && wr_in;

  // Write-first: a same-cycle write to the read line is returned by that read.
  always_comb begin
    rd_mux = '0;
    if (serving && rd_in) rd_mux = (wr_en && (widx == ridx)) ? wdata : mem[ridx];
  end

  // Gated by reset so an interrupted clear leaves the current line untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) mem[clr_ptr] <= '0;
      else if (wr_en)        mem[widx]    <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
      acc_err <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (wdata_vld) acc_err <= 1'b1;
          if (clr_ptr == IW'(DEPTH - 1)) state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
          if (wr_en) wr_cnt <= sat_inc(wr_cnt);
          if (raddr_vld && rd_in) rd_cnt <= sat_inc(rd_cnt);
          if ((wdata_vld && !wr_in) || (raddr_vld && !rd_in)) acc_err <= 1'b1;
          if (state == ST_IDLE && clr_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            acc_err <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_done = (state == ST_DONE);

  tpbuf_rd_pipe #(
    .DATA_W (DW),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (raddr_vld),
    .load_data (rd_mux),
    .rsp_vld   (pipe_vld),
    .rsp_data  (pipe_data)
  );

  assign rdata_vld = pipe_vld;
  assign rdata     = pipe_vld ? pipe_data : '0;

endmodule
